// File: rtl/dram_cmd_gen_pkg.sv
// Shared types for the DRAM request-side command generator: packed command word,
// linear address layout and the packing helper.
package dram_cmd_gen_pkg;

  localparam int ROW_W      = 13;
  localparam int BANK_W     = 3;
  localparam int COL_W      = 10;
  localparam int BURST_COLS = 8;
  localparam int ADDR_W     = ROW_W + BANK_W + COL_W;

  typedef struct packed {
    logic              r_w;
    logic              rsvd30;
    logic [ROW_W-1:0]  row;
    logic              rsvd16;
    logic              burst_length;
    logic              rsvd14;
    logic              auto_precharge;
    logic [COL_W-1:0]  col;
    logic [BANK_W-1:0] bank;
  } command_t;

  // Column is least significant, so a plain add carries col -> bank -> row.
  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;
    logic [COL_W-1:0]  col;
  } lin_addr_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  function automatic command_t pack_cmd(input logic rw, input logic ap, input lin_addr_t a);
    command_t c;
    c                = '0;
    c.r_w            = rw;
    c.row            = a.row;
    c.burst_length   = 1'b1;
    c.auto_precharge = ap;
    c.col            = a.col;
    c.bank           = a.bank;
    return c;
  endfunction

endpackage

// File: rtl/dram_cmd_gen_if.sv
// Request and command streams between the host front-end, the command generator
// and the controller's command queue.
interface dram_cmd_gen_if #(
  parameter int MAX_LEN_W = 8
);
  import dram_cmd_gen_pkg::*;

  // Both streams use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; a producer holds valid and its payload stable until then, and
  // ready may rise before valid.
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_rw;
  logic [ADDR_W-1:0]    req_addr;
  logic [MAX_LEN_W-1:0] req_len;
  logic                 req_ap;
  logic                 cmd_valid;
  logic                 cmd_ready;
  command_t             cmd_out;

  modport master (
    output req_valid, req_rw, req_addr, req_len, req_ap, cmd_ready,
    input  req_ready, cmd_valid, cmd_out
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_len, req_ap, cmd_ready,
    output req_ready, cmd_valid, cmd_out
  );

endinterface

// File: rtl/dram_cmd_gen.sv
// Splits a linear host request of 1..256 BL8 bursts into one command per burst,
// walking the address across column, bank and row boundaries.
module dram_cmd_gen
  import dram_cmd_gen_pkg::*;
#(
  parameter int MAX_LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dram_cmd_gen_if.slave         bus,
  output logic                  busy,
  output state_t                dbg_state
);

  state_t               state_q, state_d;
  lin_addr_t            addr_q, addr_d;
  logic [MAX_LEN_W-1:0] cnt_q, cnt_d;
  logic                 rw_q, rw_d;
  logic                 ap_q, ap_d;
  command_t             cmd_q, cmd_d;
  logic                 valid_q;
  logic                 ready_q;
  logic [ADDR_W-1:0]    addr_next;
  logic                 handshake;

  assign handshake = valid_q && bus.cmd_ready;

  // The next command word is built here and registered, so cmd_out never depends
  // combinationally on cmd_ready or req_valid.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    ap_d      = ap_q;
    cmd_d     = cmd_q;
    addr_next = addr_q + ADDR_W'(BURST_COLS);
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && ready_q) begin
          rw_d    = bus.req_rw;
          ap_d    = bus.req_ap;
          cnt_d   = bus.req_len;
          addr_d  = lin_addr_t'(bus.req_addr & ~ADDR_W'(BURST_COLS - 1));
          cmd_d   = pack_cmd(bus.req_rw, bus.req_ap && (bus.req_len == '0), addr_d);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (handshake) begin
          if (cnt_q == '0) begin
            cmd_d   = '0;
            state_d = ST_IDLE;
          end else begin
            addr_d = lin_addr_t'(addr_next);
            cnt_d  = cnt_q - MAX_LEN_W'(1);
            cmd_d  = pack_cmd(rw_q, ap_q && (cnt_d == '0), addr_d);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // req_ready resets low and rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      ap_q    <= 1'b0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      ap_q    <= ap_d;
      cmd_q   <= cmd_d;
      valid_q <= (state_d == ST_ISSUE);
      ready_q <= (state_d == ST_IDLE);
    end
  end

  assign bus.cmd_out   = cmd_q;
  assign bus.cmd_valid = valid_q;
  assign bus.req_ready = ready_q;
  assign busy          = (state_q == ST_ISSUE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dram_cmd_gen.sv
// Bench for dram_cmd_gen: directed vector table, hand-written corner sequences and
// random requests scored against an arithmetic model of the address walk.
module tb_dram_cmd_gen;
  import dram_cmd_gen_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   busy;
  state_t dbg_state;

  dram_cmd_gen_if #(.MAX_LEN_W(8)) bus ();

  dram_cmd_gen #(.MAX_LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors;
  int          checks;
  logic [31:0] exp_q[$];
  logic        rnd_mode;
  logic        prev_stall;
  logic [31:0] prev_out;

  typedef struct {
    string            name;
    logic             rw;
    logic [25:0]      addr;
    logic [7:0]       len;
    logic             ap;
    int               n;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Expected command i of a request, from the address as a linear burst index.
  function automatic logic [31:0] model_cmd(input logic rw, input logic ap, input logic [25:0] addr,
                                            input int unsigned i, input int unsigned len);
    int unsigned lin, row, bank, col;
    lin  = ((32'(addr) >> 3) + i) % (32'd1 << 23);
    col  = (lin % 128) * 8;
    bank = (lin / 128) % 8;
    row  = (lin / 1024) % 8192;
    return {rw, 1'b0, 13'(row), 1'b0, 1'b1, 1'b0, (ap && (i == len)), 10'(col), 3'(bank)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bus.cmd_valid)
        check("hold_stable", bus.cmd_out, prev_out);
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got %h expected none", bus.cmd_out);
        end else begin
          check("cmd", bus.cmd_out, exp_q.pop_front());
        end
      end
      prev_stall = bus.cmd_valid && !bus.cmd_ready;
      prev_out   = bus.cmd_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) bus.cmd_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic scramble_req();
    bus.req_rw   = 1'($urandom_range(0, 1));
    bus.req_addr = 26'($urandom);
    bus.req_len  = 8'($urandom);
    bus.req_ap   = 1'($urandom_range(0, 1));
  endtask

  task automatic send_req(input logic rw, input logic [25:0] addr, input logic [7:0] len, input logic ap);
    int n;
    n = 0;
    while (!bus.req_ready && n < 3000) begin
      tick();
      n++;
    end
    if (!bus.req_ready) begin
      fail_note("req_ready_wait");
    end else begin
      bus.req_valid = 1'b1;
      bus.req_rw    = rw;
      bus.req_addr  = addr;
      bus.req_len   = len;
      bus.req_ap    = ap;
      tick();
      bus.req_valid = 1'b0;
      scramble_req();
    end
  endtask

  task automatic push_model(input logic rw, input logic [25:0] addr, input logic [7:0] len, input logic ap);
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back(model_cmd(rw, ap, addr, i, len));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.cmd_valid) && n < 5000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || bus.cmd_valid) begin
      fail_note(name);
      exp_q.delete();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic        rw, ap;
    logic [25:0] addr;
    logic [7:0]  len;

    errors        = 0;
    checks        = 0;
    rnd_mode      = 1'b0;
    prev_stall    = 1'b0;
    prev_out      = '0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.cmd_ready = 1'b0;
    scramble_req();

    vecs[0] = '{name: "single_read", rw: 1'b1, addr: 26'h000A810, len: 8'd0, ap: 1'b1, n: 1,
                exp: {32'h0, 32'h0, 32'h0, 32'h800AA082}};
    vecs[1] = '{name: "carry", rw: 1'b0, addr: 26'h00C9FF8, len: 8'd2, ap: 1'b0, n: 3,
                exp: {32'h0, 32'h00CA8040, 32'h00CA8000, 32'h00C89FC7}};
    vecs[2] = '{name: "top_wrap", rw: 1'b1, addr: 26'h3FFFFF8, len: 8'd1, ap: 1'b1, n: 2,
                exp: {32'h0, 32'h0, 32'h8000A000, 32'hBFFE9FC7}};
    vecs[3] = '{name: "unaligned", rw: 1'b0, addr: 26'h000000D, len: 8'd0, ap: 1'b0, n: 1,
                exp: {32'h0, 32'h0, 32'h0, 32'h00008040}};

    // Reset values, and req_ready rising one edge after release.
    #2;
    check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_cmd_out", bus.cmd_out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(bus.req_ready), 32'd0);
    tick();
    check("ready_after_edge", 32'(bus.req_ready), 32'd1);

    // Directed vector table.
    bus.cmd_ready = 1'b1;
    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].n; i++) exp_q.push_back(vecs[k].exp[i]);
      send_req(vecs[k].rw, vecs[k].addr, vecs[k].len, vecs[k].ap);
      drain({"drain_", vecs[k].name});
    end

    // Single-request timing: first command after accept, one bubble after last handshake.
    exp_q.push_back(32'h800AA082);
    send_req(1'b1, 26'h000A810, 8'd0, 1'b1);
    check("t_cmd_valid", 32'(bus.cmd_valid), 32'd1);
    check("t_req_ready_low", 32'(bus.req_ready), 32'd0);
    check("t_busy", 32'(busy), 32'd1);
    check("t_cmd_out", bus.cmd_out, 32'h800AA082);
    tick();
    check("t_valid_drop", 32'(bus.cmd_valid), 32'd0);
    check("t_req_ready_back", 32'(bus.req_ready), 32'd1);
    drain("drain_timing");

    // Backpressure for three cycles in the middle of a six-burst request.
    addr = 26'h01237F0;
    push_model(1'b1, addr, 8'd5, 1'b1);
    send_req(1'b1, addr, 8'd5, 1'b1);
    tick();
    tick();
    bus.cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", 32'(bus.cmd_valid), 32'd1);
      check("bp_held", bus.cmd_out, model_cmd(1'b1, 1'b1, addr, 2, 5));
    end
    bus.cmd_ready = 1'b1;
    drain("drain_backpressure");

    // Request inputs toggled while busy must not disturb the issued sequence.
    addr = 26'h0012345;
    push_model(1'b0, addr, 8'd2, 1'b1);
    bus.cmd_ready = 1'b0;
    send_req(1'b0, addr, 8'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1;
      scramble_req();
      tick();
      check("ign_busy", 32'(busy), 32'd1);
    end
    bus.req_valid = 1'b0;
    bus.cmd_ready = 1'b1;
    drain("drain_ignore");

    // Reset during burst 2 of 4.
    addr = 26'h0400100;
    push_model(1'b1, addr, 8'd3, 1'b0);
    send_req(1'b1, addr, 8'd3, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("mr_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("mr_cmd_out", bus.cmd_out, 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    #1;
    check("mr_ready_low", 32'(bus.req_ready), 32'd0);
    tick();
    check("mr_ready_high", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mr_no_cmd", 32'(bus.cmd_valid), 32'd0);
    end

    // Random requests with random backpressure.
    rnd_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rw   = 1'($urandom_range(0, 1));
      ap   = 1'($urandom_range(0, 1));
      addr = 26'($urandom);
      if (k % 5 == 0) addr = 26'h3FFFFFF - 26'($urandom_range(0, 64));
      len  = (k == 0) ? 8'd255 : 8'($urandom_range(0, 12));
      push_model(rw, addr, len, ap);
      send_req(rw, addr, len, ap);
    end
    drain("drain_random");
    rnd_mode      = 1'b0;
    bus.cmd_ready = 1'b1;
    tick();
    check("end_idle", 32'(bus.req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
